// File: rtl/sd_card_init.sv
// sd_card_init: power-up initialisation sequencer for an SD card in native 1-bit mode.
// It drives the command controller through CMD0, CMD8, CMD55/ACMD41, CMD2, CMD3 and CMD7.
// It then reports the card type and RCA to the data path.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   init_start_i           start/restart pulse, honoured only when init_busy_o=0
//   cmd_start_o            one-cycle start pulse to the command controller
//   cmd_precycles_o        idle SD clocks before the command (80 for CMD0, else 8)
//   cmd_clkdiv_o           SLOW_CLKDIV during identification, FAST_CLKDIV once done
//   cmd_idx_o, cmd_arg_o   command index and argument
//   cmd_busy_i, cmd_done_i controller status; done is a one-cycle pulse
//   cmd_timeout_i          controller status, qualified by cmd_done_i
//   cmd_syntaxerr_i        controller status, qualified by cmd_done_i
//   cmd_resparg_i          short-response argument, valid with cmd_done_i
//   init_busy_o            sequence in progress
//   init_done_o            card in transfer state
//   init_err_o             sequence aborted
//   err_code_o             abort cause
//   card_v2_o              card answered CMD8
//   card_sdhc_o            CCS bit from the final ACMD41
//   rca_o                  relative card address
module sd_card_init #(
   parameter logic [15:0] SLOW_CLKDIV = 16'd49,
   parameter logic [15:0] FAST_CLKDIV = 16'd1,
   parameter logic [15:0] MAX_RETRY   = 16'd1000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        init_start_i,
   output logic        cmd_start_o,
   output logic [15:0] cmd_precycles_o,
   output logic [15:0] cmd_clkdiv_o,
   output logic [5:0]  cmd_idx_o,
   output logic [31:0] cmd_arg_o,
   input  logic        cmd_busy_i,
   input  logic        cmd_done_i,
   input  logic        cmd_timeout_i,
   input  logic        cmd_syntaxerr_i,
   input  logic [31:0] cmd_resparg_i,
   output logic        init_busy_o,
   output logic        init_done_o,
   output logic        init_err_o,
   output logic [3:0]  err_code_o,
   output logic        card_v2_o,
   output logic        card_sdhc_o,
   output logic [15:0] rca_o
);

   typedef enum logic [3:0] {
      StIdle, StCmd0, StCmd8, StCmd55, StAcmd41, StCmd2, StCmd3, StCmd7, StDone, StErr
   } state_e;

   state_e      state_q, eval_st;
   logic        wait_q;  // 0: ISSUE phase, 1: WAIT phase
   logic        cmd_start_q;
   logic [15:0] cmd_precycles_q, cmd_clkdiv_q;
   logic [5:0]  cmd_idx_q;
   logic [31:0] cmd_arg_q;
   logic        init_busy_q, init_done_q, init_err_q;
   logic [3:0]  err_code_q, eval_code;
   logic        card_v2_q, card_sdhc_q, eval_v2, eval_sdhc;
   logic [15:0] rca_q, eval_rca;
   logic [15:0] retry_q, retry_inc, eval_retry;
   logic        unused_resp;

   assign unused_resp = ^cmd_resparg_i[15:12];

   function automatic logic [5:0] idx_of(input state_e st);
      case (st)
         StCmd8:   return 6'd8;
         StCmd55:  return 6'd55;
         StAcmd41: return 6'd41;
         StCmd2:   return 6'd2;
         StCmd3:   return 6'd3;
         StCmd7:   return 6'd7;
         default:  return 6'd0;
      endcase
   endfunction

   function automatic logic [31:0] arg_of(input state_e st, input logic v2,
                                          input logic [15:0] rca);
      case (st)
         StCmd8:   return 32'h0000_01AA;
         StAcmd41: return v2 ? 32'h40FF_8000 : 32'h00FF_8000;
         StCmd7:   return {rca, 16'h0000};
         default:  return 32'h0000_0000;
      endcase
   endfunction

   // Saturating increment; the MAX_RETRY compare fires before wrap is possible.
   assign retry_inc = (retry_q == 16'hFFFF) ? retry_q : retry_q + 16'd1;

   // Outcome of the command in flight, applied only in the WAIT-phase cmd_done cycle.
   always_comb begin
      eval_st    = state_q;
      eval_code  = err_code_q;
      eval_v2    = card_v2_q;
      eval_sdhc  = card_sdhc_q;
      eval_rca   = rca_q;
      eval_retry = retry_q;
      case (state_q)
         StCmd0: eval_st = StCmd8;
         StCmd8: begin
            if (cmd_timeout_i) begin
               eval_v2 = 1'b0;
               eval_st = StCmd55;
            end else if (cmd_syntaxerr_i) begin
               eval_st   = StErr;
               eval_code = 4'd8;
            end else if (cmd_resparg_i[11:0] == 12'h1AA) begin
               eval_v2 = 1'b1;
               eval_st = StCmd55;
            end else begin
               eval_st   = StErr;
               eval_code = 4'd1;
            end
         end
         StCmd55: begin
            if (cmd_timeout_i || cmd_syntaxerr_i) begin
               eval_st   = StErr;
               eval_code = 4'd2;
            end else begin
               eval_st = StAcmd41;
            end
         end
         StAcmd41: begin
            // R3 carries no CRC, so syntaxerr is meaningless here.
            if (cmd_timeout_i) begin
               eval_st   = StErr;
               eval_code = 4'd3;
            end else if (cmd_resparg_i[31]) begin
               eval_sdhc = cmd_resparg_i[30];
               eval_st   = StCmd2;
            end else begin
               eval_retry = retry_inc;
               if (retry_inc == MAX_RETRY) begin
                  eval_st   = StErr;
                  eval_code = 4'd4;
               end else begin
                  eval_st = StCmd55;
               end
            end
         end
         StCmd2: begin
            if (cmd_timeout_i) begin
               eval_st   = StErr;
               eval_code = 4'd5;
            end else begin
               eval_st = StCmd3;
            end
         end
         StCmd3: begin
            if (cmd_timeout_i || cmd_syntaxerr_i) begin
               eval_st   = StErr;
               eval_code = 4'd6;
            end else begin
               eval_rca = cmd_resparg_i[31:16];
               if (cmd_resparg_i[31:16] == 16'h0000) begin
                  // A zero RCA is unusable; ask again, sharing the ACMD41 retry budget.
                  eval_retry = retry_inc;
                  if (retry_inc == MAX_RETRY) begin
                     eval_st   = StErr;
                     eval_code = 4'd6;
                  end else begin
                     eval_st = StCmd3;
                  end
               end else begin
                  eval_st = StCmd7;
               end
            end
         end
         StCmd7: begin
            if (cmd_timeout_i || cmd_syntaxerr_i) begin
               eval_st   = StErr;
               eval_code = 4'd7;
            end else begin
               eval_st = StDone;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= StIdle;
         wait_q          <= 1'b0;
         cmd_start_q     <= 1'b0;
         cmd_precycles_q <= 16'd80;
         cmd_clkdiv_q    <= SLOW_CLKDIV;
         cmd_idx_q       <= 6'd0;
         cmd_arg_q       <= 32'h0;
         init_busy_q     <= 1'b0;
         init_done_q     <= 1'b0;
         init_err_q      <= 1'b0;
         err_code_q      <= 4'd0;
         card_v2_q       <= 1'b0;
         card_sdhc_q     <= 1'b0;
         rca_q           <= 16'h0;
         retry_q         <= 16'h0;
      end else begin
         cmd_start_q <= 1'b0;
         case (state_q)
            StIdle, StDone, StErr: begin
               if (init_start_i) begin
                  state_q         <= StCmd0;
                  wait_q          <= 1'b0;
                  cmd_idx_q       <= 6'd0;
                  cmd_arg_q       <= 32'h0;
                  cmd_precycles_q <= 16'd80;
                  cmd_clkdiv_q    <= SLOW_CLKDIV;
                  init_busy_q     <= 1'b1;
                  init_done_q     <= 1'b0;
                  init_err_q      <= 1'b0;
                  err_code_q      <= 4'd0;
                  card_v2_q       <= 1'b0;
                  card_sdhc_q     <= 1'b0;
                  rca_q           <= 16'h0;
                  retry_q         <= 16'h0;
               end
            end
            default: begin
               if (!wait_q) begin
                  // Stale done pulses in ISSUE are ignored and also hold off the start.
                  if (!cmd_busy_i && !cmd_done_i) begin
                     cmd_start_q <= 1'b1;
                     wait_q      <= 1'b1;
                  end
               end else if (cmd_done_i) begin
                  state_q     <= eval_st;
                  wait_q      <= 1'b0;
                  err_code_q  <= eval_code;
                  card_v2_q   <= eval_v2;
                  card_sdhc_q <= eval_sdhc;
                  rca_q       <= eval_rca;
                  retry_q     <= eval_retry;
                  if (eval_st == StDone) begin
                     init_busy_q  <= 1'b0;
                     init_done_q  <= 1'b1;
                     cmd_clkdiv_q <= FAST_CLKDIV;
                  end else if (eval_st == StErr) begin
                     init_busy_q <= 1'b0;
                     init_err_q  <= 1'b1;
                  end else begin
                     cmd_idx_q       <= idx_of(eval_st);
                     cmd_arg_q       <= arg_of(eval_st, eval_v2, eval_rca);
                     cmd_precycles_q <= (eval_st == StCmd0) ? 16'd80 : 16'd8;
                  end
               end
            end
         endcase
      end
   end

   assign cmd_start_o     = cmd_start_q;
   assign cmd_precycles_o = cmd_precycles_q;
   assign cmd_clkdiv_o    = cmd_clkdiv_q;
   assign cmd_idx_o       = cmd_idx_q;
   assign cmd_arg_o       = cmd_arg_q;
   assign init_busy_o     = init_busy_q;
   assign init_done_o     = init_done_q;
   assign init_err_o      = init_err_q;
   assign err_code_o      = err_code_q;
   assign card_v2_o       = card_v2_q;
   assign card_sdhc_o     = card_sdhc_q;
   assign rca_o           = rca_q;

endmodule

// File: tb/tb_sd_card_init.sv
// tb_sd_card_init: bench for sd_card_init.
// It pairs a command-controller/card model with a story-level reference of the init sequence.
module tb_sd_card_init;
   localparam logic [15:0] SLOW = 16'd49;
   localparam logic [15:0] FAST = 16'd1;
   localparam int          MAXR = 3;
   localparam logic [5:0]  NONE = 6'd63;
   localparam logic [95:0] RST_VAL = {1'b0, 16'd80, SLOW, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0,
                                      4'd0, 1'b0, 1'b0, 16'd0};

   logic        clk = 1'b0;
   logic        rst_n, init_start;
   logic        cmd_start, cmd_busy, cmd_done, cmd_timeout, cmd_syntaxerr;
   logic [15:0] cmd_precycles, cmd_clkdiv, rca;
   logic [5:0]  cmd_idx;
   logic [31:0] cmd_arg, cmd_resparg;
   logic        init_busy, init_done, init_err, card_v2, card_sdhc;
   logic [3:0]  err_code;

   sd_card_init #(
      .SLOW_CLKDIV (SLOW),
      .FAST_CLKDIV (FAST),
      .MAX_RETRY   (16'(MAXR))
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .init_start_i    (init_start),
      .cmd_start_o     (cmd_start),
      .cmd_precycles_o (cmd_precycles),
      .cmd_clkdiv_o    (cmd_clkdiv),
      .cmd_idx_o       (cmd_idx),
      .cmd_arg_o       (cmd_arg),
      .cmd_busy_i      (cmd_busy),
      .cmd_done_i      (cmd_done),
      .cmd_timeout_i   (cmd_timeout),
      .cmd_syntaxerr_i (cmd_syntaxerr),
      .cmd_resparg_i   (cmd_resparg),
      .init_busy_o     (init_busy),
      .init_done_o     (init_done),
      .init_err_o      (init_err),
      .err_code_o      (err_code),
      .card_v2_o       (card_v2),
      .card_sdhc_o     (card_sdhc),
      .rca_o           (rca)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail = 0;

   // Card behaviour for the current scenario.
   int          sc_mode;  // 0 echoes CMD8, 1 CMD8 timeout, 2 bad echo, 3 CMD8 syntaxerr
   int          sc_busy;  // ACMD41 not-ready answers before ready
   logic        sc_ccs;
   logic [15:0] sc_rca;
   int          sc_zero;  // CMD3 answers with rca=0 before the real one
   logic [5:0]  sc_to, sc_se;  // command whose first issue times out / flags syntaxerr

   logic [69:0] obs_q[$];
   logic [69:0] exp_q[$];
   logic [95:0] exp_stat;
   int          occ[64];
   int          prot_err, stab_err, done_cyc;
   logic        inj_done = 1'b0;
   logic [5:0]  inj_tbl[6] = '{6'd0, 6'd55, 6'd41, 6'd2, 6'd3, 6'd7};

   task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [69:0] cur_cmd();
      return {cmd_idx, cmd_arg, cmd_precycles, cmd_clkdiv};
   endfunction

   function automatic logic [69:0] cmdv(input logic [5:0] i, input logic [31:0] a);
      return {i, a, (i == 6'd0) ? 16'd80 : 16'd8, SLOW};
   endfunction

   function automatic logic [95:0] full_now();
      return {cmd_start, cmd_precycles, cmd_clkdiv, cmd_idx, cmd_arg, init_busy, init_done,
              init_err, err_code, card_v2, card_sdhc, rca};
   endfunction

   function automatic logic [95:0] stat_now();
      return {54'd0, cmd_start, cmd_clkdiv, init_busy, init_done, init_err, err_code, card_v2,
              card_sdhc, rca};
   endfunction

   task automatic set_sc(input int mode, input int busy, input logic ccs, input logic [15:0] r,
                         input int zero, input logic [5:0] to, input logic [5:0] se);
      sc_mode = mode; sc_busy = busy; sc_ccs = ccs; sc_rca = r;
      sc_zero = zero; sc_to = to; sc_se = se;
   endtask

   // Reference: tell the card's story command by command and predict the outcome.
   task automatic run_model();
      logic        v2, sdhc;
      logic [15:0] r;
      logic [3:0]  code;
      int          retry, n41, n3;
      v2 = 1'b0; sdhc = 1'b0; r = 16'h0; code = 4'd0; retry = 0; n41 = 0; n3 = 0;
      exp_q.delete();
      exp_q.push_back(cmdv(6'd0, 32'h0));
      exp_q.push_back(cmdv(6'd8, 32'h1AA));
      if (sc_mode == 2) code = 4'd1;
      else if (sc_mode == 3) code = 4'd8;
      else v2 = (sc_mode == 0);
      if (code == 4'd0) begin
         for (int k = 0; k < 1000; k++) begin
            exp_q.push_back(cmdv(6'd55, 32'h0));
            if (k == 0 && (sc_to == 6'd55 || sc_se == 6'd55)) begin code = 4'd2; break; end
            exp_q.push_back(cmdv(6'd41, v2 ? 32'h40FF8000 : 32'h00FF8000));
            if (n41 == 0 && sc_to == 6'd41) begin code = 4'd3; break; end
            if (n41 >= sc_busy) begin sdhc = sc_ccs; break; end
            n41++; retry++;
            if (retry == MAXR) begin code = 4'd4; break; end
         end
      end
      if (code == 4'd0) begin
         exp_q.push_back(cmdv(6'd2, 32'h0));
         if (sc_to == 6'd2) code = 4'd5;
      end
      if (code == 4'd0) begin
         for (int k = 0; k < 1000; k++) begin
            exp_q.push_back(cmdv(6'd3, 32'h0));
            if (k == 0 && (sc_to == 6'd3 || sc_se == 6'd3)) begin code = 4'd6; break; end
            if (n3 < sc_zero) begin
               r = 16'h0; n3++; retry++;
               if (retry == MAXR) begin code = 4'd6; break; end
            end else begin
               r = sc_rca; break;
            end
         end
      end
      if (code == 4'd0) begin
         exp_q.push_back(cmdv(6'd7, {r, 16'h0}));
         if (sc_to == 6'd7 || sc_se == 6'd7) code = 4'd7;
      end
      exp_stat = {54'd0, 1'b0, (code == 4'd0) ? FAST : SLOW, 1'b0, code == 4'd0, code != 4'd0,
                  code, v2, sdhc, r};
   endtask

   task automatic respond(input logic [5:0] ci);
      int k;
      k = occ[ci];
      occ[ci]++;
      cmd_resparg   = $urandom;
      cmd_timeout   = (ci == sc_to && k == 0);
      cmd_syntaxerr = (ci == sc_se && k == 0);
      case (ci)
         6'd8: begin
            case (sc_mode)
               0: cmd_resparg = {cmd_resparg[31:12], 12'h1AA};
               1: cmd_timeout = 1'b1;
               2: cmd_resparg = 32'h000001A5;
               default: cmd_syntaxerr = 1'b1;
            endcase
         end
         6'd41: cmd_resparg = (k < sc_busy) ? 32'h00FF8000 :
                              (sc_ccs ? 32'hC0FF8000 : 32'h80FF8000);
         6'd3: cmd_resparg = (k < sc_zero) ? 32'h00000500 : {sc_rca, 16'h0500};
         default: ;
      endcase
   endtask

   // Command controller + card: accept start, stay busy a random time, pulse done.
   initial begin : ctrl
      int          lat;
      logic [69:0] cap;
      logic [5:0]  ci;
      logic        prev_start;
      cmd_busy = 1'b0; cmd_done = 1'b0; cmd_timeout = 1'b0; cmd_syntaxerr = 1'b0;
      cmd_resparg = 32'h0; prev_start = 1'b0; lat = 0; cap = '0; ci = 6'd0;
      prot_err = 0; stab_err = 0; done_cyc = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            cmd_busy = 1'b0; cmd_done = 1'b0; cmd_timeout = 1'b0; cmd_syntaxerr = 1'b0;
            prev_start = 1'b0;
            continue;
         end
         if (cmd_start && (cmd_busy || cmd_done || prev_start)) prot_err++;
         prev_start = cmd_start;
         cmd_done = 1'b0; cmd_timeout = 1'b0; cmd_syntaxerr = 1'b0;
         if (cmd_busy) begin
            if (cur_cmd() !== cap) stab_err++;
            if (lat == 0) begin
               respond(ci);
               cmd_busy = 1'b0;
               cmd_done = 1'b1;
               done_cyc = cyc;
            end else begin
               lat--;
            end
         end else if (cmd_start) begin
            cap = cur_cmd();
            obs_q.push_back(cap);
            ci = cmd_idx;
            cmd_busy = 1'b1;
            lat = $urandom_range(0, 3);
         end else if (inj_done) begin
            inj_done = 1'b0;
            cmd_done = 1'b1;
            cmd_timeout = 1'b1;
            cmd_resparg = $urandom;
         end
      end
   end

   task automatic run_sc(input string tag, input int dbl_at);
      int n;
      run_model();
      foreach (occ[i]) occ[i] = 0;
      obs_q.delete();
      prot_err = 0;
      stab_err = 0;
      init_start = 1'b1;
      @(negedge clk);
      init_start = 1'b0;
      check_eq({tag, "/busy"}, 96'(init_busy), 96'd1);
      n = 0;
      forever begin
         @(negedge clk);
         init_start = 1'b0;
         if (!init_busy || n >= 3000) break;
         n++;
         if (n == dbl_at) init_start = 1'b1;  // must be ignored while busy
      end
      check_eq({tag, "/term"}, 96'(n < 3000), 96'd1);
      check_eq({tag, "/lat"}, 96'(cyc - done_cyc), 96'd1);
      check_eq({tag, "/stat"}, stat_now(), exp_stat);
      repeat (10) @(negedge clk);
      check_eq({tag, "/ncmd"}, 96'(obs_q.size()), 96'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         check_eq($sformatf("%s/cmd%0d", tag, i), 96'(obs_q[i]), 96'(exp_q[i]));
      check_eq({tag, "/proto"}, 96'(prot_err + stab_err), 96'd0);
   endtask

   initial begin : main
      int          n, nobs, r;
      logic [69:0] c;
      rst_n = 1'b0;
      init_start = 1'b0;
      set_sc(0, 0, 1'b0, 16'h1, 0, NONE, NONE);
      repeat (3) @(negedge clk);
      check_eq("reset_vals", full_now(), RST_VAL);
      rst_n = 1'b1;
      @(negedge clk);
      inj_done = 1'b1;
      repeat (5) @(negedge clk);
      check_eq("stale_done_idle", full_now(), RST_VAL);
      check_eq("stale_done_nocmd", 96'(obs_q.size()), 96'd0);

      set_sc(0, 2, 1'b1, 16'hAAAA, 0, NONE, NONE);      run_sc("v2hc", 0);
      set_sc(1, 0, 1'b0, 16'h5678, 0, NONE, NONE);      run_sc("v1", 0);
      set_sc(2, 0, 1'b0, 16'h5678, 0, NONE, NONE);      run_sc("bad_cmd8", 0);
      set_sc(0, 100, 1'b0, 16'h5678, 0, NONE, NONE);    run_sc("retry_max", 0);
      set_sc(0, 0, 1'b1, 16'h0042, 1, NONE, NONE);      run_sc("rca_zero", 5);
      set_sc(1, 0, 1'b0, 16'h0101, 0, NONE, 6'd2);      run_sc("cmd2_se", 0);

      for (int s = 0; s < 16; s++) begin
         r = $urandom_range(0, 9);
         sc_mode = (r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
         sc_busy = $urandom_range(0, 3);
         sc_ccs  = 1'($urandom_range(0, 1));
         sc_rca  = 16'($urandom_range(1, 65535));
         sc_zero = $urandom_range(0, 2);
         r = $urandom_range(0, 11);
         sc_to = (r < 6) ? inj_tbl[r] : NONE;
         r = $urandom_range(0, 11);
         sc_se = (r < 6) ? inj_tbl[r] : NONE;
         run_sc($sformatf("rnd%0d", s), $urandom_range(1, 80));
      end

      // Reset while CMD55 is outstanding.
      set_sc(0, 1, 1'b1, 16'h1234, 0, NONE, NONE);
      foreach (occ[i]) occ[i] = 0;
      obs_q.delete();
      init_start = 1'b1;
      @(negedge clk);
      init_start = 1'b0;
      n = 0;
      while (n < 500 && obs_q.size() < 3) begin
         @(negedge clk);
         n++;
      end
      check_eq("rst/reach", 96'(obs_q.size() >= 3), 96'd1);
      c = (obs_q.size() >= 3) ? obs_q[2] : '0;
      check_eq("rst/is55", 96'(c[69:64]), 96'd55);
      rst_n = 1'b0;
      nobs = obs_q.size();
      repeat (2) @(negedge clk);
      check_eq("rst/vals", full_now(), RST_VAL);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check_eq("rst/quiet", 96'(obs_q.size()), 96'(nobs));
      check_eq("rst/idle", full_now(), RST_VAL);
      run_sc("restart", 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sd_card_init.md
# sd_card_init

Power-up initialisation sequencer for an SD card in native 1-bit SD mode. It sits directly upstream of the SD command controller and drives that controller's start/cmd/arg/clkdiv/precycles inputs. It consumes the controller's done/timeout/syntaxerr/response outputs. It walks the card through CMD0, CMD8, CMD55/ACMD41, CMD2, CMD3 and CMD7, then reports the card type and RCA to the data-path logic.

## Interface
Parameters:
- SLOW_CLKDIV, 16'd49: clkdiv used during identification; SD clock period is 2*(clkdiv+1) clk cycles.
- FAST_CLKDIV, 16'd1: clkdiv advertised after successful init.
- MAX_RETRY, 16'd1000: maximum CMD55/ACMD41 loop iterations.

Ports:
- clk  in  1  system clock; only clock of the block.
- rst_n  in  1  asynchronous, active-low reset.
- init_start  in  1  pulse that starts or restarts initialisation; honoured only when init_busy=0.
- cmd_start  out  1  one-cycle start pulse to the command controller.
- cmd_precycles  out  16  idle SD clocks before the command: 80 for CMD0, 8 for all others.
- cmd_clkdiv  out  16  SLOW_CLKDIV until init_done, then FAST_CLKDIV.
- cmd_idx  out  6  command index.
- cmd_arg  out  32  command argument.
- cmd_busy, cmd_done, cmd_timeout, cmd_syntaxerr  in  1 each  controller status; done is a one-cycle pulse.
- cmd_resparg  in  32  short-response argument; valid in the cmd_done cycle.
- init_busy  out  1  sequence in progress.
- init_done  out  1  level; card is in transfer state.
- init_err  out  1  level; sequence aborted.
- err_code  out  4  cause of abort; 0 when no error.
- card_v2  out  1  card answered CMD8 correctly.
- card_sdhc  out  1  CCS bit from the final ACMD41.
- rca  out  16  relative card address from CMD3.

## Operation
- States: IDLE, CMD0, CMD8, CMD55, ACMD41, CMD2, CMD3, CMD7, DONE, ERR.
- Each command state has two phases, ISSUE and WAIT.
  - ISSUE: cmd_idx, cmd_arg and cmd_precycles are set to the state's values. cmd_start pulses in the first cycle with cmd_busy=0, then the phase moves to WAIT.
  - WAIT: the state waits for cmd_done and evaluates the result in that same cycle.
- Command arguments:
  - CMD0, CMD2, CMD3, CMD55: 0.
  - CMD8: 32'h000001AA.
  - ACMD41: 32'h40FF8000 if card_v2, else 32'h00FF8000.
  - CMD7: {rca,16'h0}.
- CMD0: the result is ignored and the sequencer always proceeds to CMD8.
- CMD8:
  - timeout → card_v2=0, go to CMD55.
  - syntaxerr → err 8.
  - cmd_resparg[11:0]==12'h1AA → card_v2=1, go to CMD55.
  - any other response → err 1.
- CMD55: timeout or syntaxerr → err 2; otherwise go to ACMD41.
- ACMD41:
  - syntaxerr is ignored because the response is R3.
  - timeout → err 3.
  - resparg[31]=1 → card_sdhc=resparg[30], go to CMD2.
  - resparg[31]=0 → retry_cnt++; if retry_cnt==MAX_RETRY → err 4, else go to CMD55.
- CMD2: syntaxerr is ignored (long response); timeout → err 5; otherwise go to CMD3.
- CMD3:
  - timeout or syntaxerr → err 6.
  - otherwise rca=resparg[31:16]; if rca==0, reissue CMD3 (this repeat counts against retry_cnt/MAX_RETRY, exhaustion → err 6); else go to CMD7.
- CMD7: timeout or syntaxerr → err 7; otherwise go to DONE.
- DONE: init_done=1, init_busy=0, cmd_clkdiv=FAST_CLKDIV.
- ERR: init_err=1, init_busy=0, err_code holds the cause.
- init_start in IDLE, DONE or ERR: clear init_done, init_err, err_code, card_v2, card_sdhc, rca and retry_cnt; set init_busy=1; enter CMD0/ISSUE.
- init_start while init_busy=1 is ignored.
- retry_cnt is 16 bits and saturates; it cannot wrap because it is compared with MAX_RETRY first.

## Timing
- Reset values: all outputs 0 except cmd_clkdiv=SLOW_CLKDIV and cmd_precycles=80. State is IDLE.
- Reset mid-sequence returns the block to IDLE immediately. No command is reissued until a new init_start.
- cmd_start is never high for two consecutive cycles.
- cmd_start is never asserted while cmd_busy=1 or in the cmd_done cycle.
- Minimum spacing from one cmd_done to the next cmd_start is 1 cycle.
- cmd_idx, cmd_arg, cmd_precycles and cmd_clkdiv are stable from the cmd_start cycle through the matching cmd_done.
- State updates (card_v2, rca, card_sdhc, err_code) become visible the cycle after cmd_done.
- init_done or init_err rises the cycle after the final cmd_done. init_busy falls in the same cycle.
- cmd_done while in ISSUE or IDLE is ignored (stale pulse).
- An init_start arriving in the same cycle as a cmd_done is ignored, because init_busy is 1 in that cycle.

## Test plan
- v2 SDHC card model: CMD8 echoes 0x1AA; ACMD41 returns 0x00FF8000 twice, then 0xC0FF8000; CMD3 returns 0xAAAA0500. Required: init_done=1, card_v2=1, card_sdhc=1, rca=16'hAAAA, CMD7 arg=32'hAAAA0000, cmd_clkdiv=FAST_CLKDIV.
- v1 card: CMD8 times out; ACMD41 returns 0x80FF8000. Required: card_v2=0, card_sdhc=0, ACMD41 arg=32'h00FF8000, init_done=1.
- CMD8 returns 0x000001A5. Required: init_err=1, err_code=1, no further cmd_start.
- With MAX_RETRY=3, ACMD41 always returns 0x00FF8000. Required: exactly 3 CMD55/ACMD41 pairs, then err_code=4.
- Mid-CMD55: assert rst_n low for 2 cycles. Required: all outputs at reset values. A subsequent init_start restarts at CMD0 with precycles=80.
- Repeat init_start while busy: no effect. Stale cmd_done in IDLE: no state change. CMD3 returning rca=0 once: CMD3 is reissued, then the sequence completes.
